// File: rtl/wb_arbiter2.sv
// Two-to-one pipelined Wishbone arbiter with per-cycle ownership and outstanding-access tracking.
// Define WB_ARB_FIXED_PRIO_EN to make m0 win every tie; otherwise ties alternate round-robin.
module wb_arbiter2 #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  // master 0
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_o,
  input  logic [DW/8-1:0] m0_sel,
  output logic            m0_stall,
  output logic            m0_ack,
  output logic            m0_err,
  output logic [DW-1:0]   m0_dat_i,
  // master 1
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_o,
  input  logic [DW/8-1:0] m1_sel,
  output logic            m1_stall,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [DW-1:0]   m1_dat_i,
  // shared slave port
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel,
  input  logic            s_stall,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic [DW-1:0]   s_dat_i
);

  localparam int unsigned CW = $clog2(MAX_OUT) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          full;
  logic          inc, dec;

  assign full = (cnt == CW'(MAX_OUT));

  // Shared-port mux and response routing; the non-owner is always held off.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_o  = '0;
    s_sel    = '0;
    m0_stall = 1'b1;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_i = '0;
    m1_stall = 1'b1;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat_i = '0;
    case (state)
      OWN0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb & ~full;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_o  = m0_dat_o;
        s_sel    = m0_sel;
        m0_stall = s_stall | full;
        m0_ack   = s_ack;
        m0_err   = s_err;
        m0_dat_i = s_dat_i;
      end
      OWN1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb & ~full;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_o  = m1_dat_o;
        s_sel    = m1_sel;
        m1_stall = s_stall | full;
        m1_ack   = s_ack;
        m1_err   = s_err;
        m1_dat_i = s_dat_i;
      end
      default: ;
    endcase
  end

  assign inc = s_stb & ~s_stall;
  // A response with nothing outstanding is forwarded but not counted.
  assign dec = (s_ack | s_err) & (cnt != '0);

`ifdef WB_ARB_FIXED_PRIO_EN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (inc && !dec) begin
      cnt_nxt = cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt_nxt = cnt - 1'b1;
    end
    case (state)
      IDLE: begin
        if (m0_cyc) begin
          state_nxt = OWN0;
        end else if (m1_cyc) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      OWN1: begin
        if (!m1_cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
`else
  logic last, last_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    if (inc && !dec) begin
      cnt_nxt = cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt_nxt = cnt - 1'b1;
    end
    case (state)
      IDLE: begin
        // On a tie the master that did not own the bus last wins.
        if (m0_cyc && (!m1_cyc || last)) begin
          state_nxt = OWN0;
          last_nxt  = 1'b0;
        end else if (m1_cyc) begin
          state_nxt = OWN1;
          last_nxt  = 1'b1;
        end
      end
      OWN0: begin
        if (!m0_cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      OWN1: begin
        if (!m1_cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: reset, pipelined reads, full throttling, tie arbitration,
// mid-cycle contention, reset during ownership and error responses.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_o;
  logic [3:0]  m0_sel;
  logic        m0_stall, m0_ack, m0_err;
  logic [31:0] m0_dat_i;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_o;
  logic [3:0]  m1_sel;
  logic        m1_stall, m1_ack, m1_err;
  logic [31:0] m1_dat_i;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_o;
  logic [3:0]  s_sel;
  logic        s_stall, s_ack, s_err;
  logic [31:0] s_dat_i;

  int checks = 0;
  int errors = 0;
  int accepts;
  int exp_owner;

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(32), .DW(32), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_o(m0_dat_o), .m0_sel(m0_sel), .m0_stall(m0_stall), .m0_ack(m0_ack),
    .m0_err(m0_err), .m0_dat_i(m0_dat_i),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_o(m1_dat_o), .m1_sel(m1_sel), .m1_stall(m1_stall), .m1_ack(m1_ack),
    .m1_err(m1_err), .m1_dat_i(m1_dat_i),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_sel(s_sel), .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err), .s_dat_i(s_dat_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after another unit.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_adr = '0; m0_dat_o = '0; m0_sel = '0;
    m1_adr = '0; m1_dat_o = '0; m1_sel = '0;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_dat_i = '0;

    // Reset state
    step(); step(); #1;
    check_eq("rst_s_cyc", 32'(s_cyc), 32'd0);
    check_eq("rst_m0_stall", 32'(m0_stall), 32'd1);
    check_eq("rst_m1_stall", 32'(m1_stall), 32'd1);
    rst = 1'b0;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
    #1;
    check_eq("idle_no_stb", 32'(s_stb), 32'd0);
    step(); #1;
    check_eq("grant0_s_stb", 32'(s_stb), 32'd1);
    check_eq("grant0_s_adr", s_adr, 32'h100);
    check_eq("grant0_s_cyc", 32'(s_cyc), 32'd1);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step(); #1;
    check_eq("abort_cnt", 32'(dut.cnt), 32'd0);
    check_eq("abort_s_cyc", 32'(s_cyc), 32'd0);

    // Three pipelined reads, acked two cycles after acceptance
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0;
    step();                                   // grant
    step(); m0_adr = 32'h4;                   // 0x0 accepted
    step(); m0_adr = 32'h8;                   // 0x4 accepted
    s_ack = 1'b1; s_dat_i = 32'hA; #1;
    check_eq("rd0_ack", 32'(m0_ack), 32'd1);
    check_eq("rd0_dat", m0_dat_i, 32'hA);
    check_eq("rd0_m1_ack", 32'(m1_ack), 32'd0);
    check_eq("rd0_m1_dat", m1_dat_i, 32'd0);
    step(); m0_stb = 1'b0; s_dat_i = 32'hB; #1;
    check_eq("rd1_ack", 32'(m0_ack), 32'd1);
    check_eq("rd1_dat", m0_dat_i, 32'hB);
    step(); s_dat_i = 32'hC; #1;
    check_eq("rd2_ack", 32'(m0_ack), 32'd1);
    check_eq("rd2_dat", m0_dat_i, 32'hC);
    check_eq("rd2_m1_ack", 32'(m1_ack), 32'd0);
    step(); s_ack = 1'b0; s_dat_i = '0; #1;
    check_eq("rd_done_ack", 32'(m0_ack), 32'd0);
    check_eq("rd_done_cnt", 32'(dut.cnt), 32'd0);
    m0_cyc = 1'b0;
    step();

    // Outstanding limit: slave never acks
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h40;
    step();                                   // grant
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (s_stb && !s_stall) accepts++;
      step();
    end
    check_eq("full_accepts", 32'(accepts), 32'd4);
    #1;
    check_eq("full_stall", 32'(m0_stall), 32'd1);
    check_eq("full_s_stb", 32'(s_stb), 32'd0);
    check_eq("full_cnt", 32'(dut.cnt), 32'd4);
    s_ack = 1'b1;
    step(); s_ack = 1'b0; #1;
    check_eq("full_reopen_stall", 32'(m0_stall), 32'd0);
    check_eq("full_reopen_stb", 32'(s_stb), 32'd1);
    step(); #1;
    check_eq("full_again_stall", 32'(m0_stall), 32'd1);
    check_eq("full_again_cnt", 32'(dut.cnt), 32'd4);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();

    // Simultaneous requests from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    m0_adr = 32'h1000; m1_adr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
      exp_owner = 0;
`else
      exp_owner = i % 2;
`endif
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; #1;
      check_eq($sformatf("tie%0d_dead", i), 32'(s_cyc), 32'd0);
      step(); #1;
      check_eq($sformatf("tie%0d_adr", i), s_adr, (exp_owner == 0) ? 32'h1000 : 32'h2000);
      check_eq($sformatf("tie%0d_m0_stall", i), 32'(m0_stall), 32'(exp_owner != 0));
      check_eq($sformatf("tie%0d_m1_stall", i), 32'(m1_stall), 32'(exp_owner != 1));
      step();
      m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b1; #1;
      check_eq($sformatf("tie%0d_m0_ack", i), 32'(m0_ack), 32'(exp_owner == 0));
      check_eq($sformatf("tie%0d_m1_ack", i), 32'(m1_ack), 32'(exp_owner == 1));
      step();
      s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
      step();
    end

    // m0 requests while m1 holds the bus
    m1_cyc = 1'b1; m1_adr = 32'h3000;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("hold%0d_m0_stall", i), 32'(m0_stall), 32'd1);
      check_eq($sformatf("hold%0d_adr", i), s_adr, 32'h3000);
      step();
    end
    m1_cyc = 1'b0;
    step(); #1;
    check_eq("rel_idle_s_cyc", 32'(s_cyc), 32'd0);
    check_eq("rel_idle_m0_stall", 32'(m0_stall), 32'd1);
    step(); #1;
    check_eq("rel_m0_stall", 32'(m0_stall), 32'd0);
    check_eq("rel_m0_adr", s_adr, 32'h5000);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();

    // Reset while m1 owns with two outstanding
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step(); step(); step();
    m1_stb = 1'b0; #1;
    check_eq("pre_rst_cnt", 32'(dut.cnt), 32'd2);
    rst = 1'b1; #1;
    check_eq("rst_own_s_cyc", 32'(s_cyc), 32'd0);
    check_eq("rst_own_cnt", 32'(dut.cnt), 32'd0);
    check_eq("rst_own_m1_stall", 32'(m1_stall), 32'd1);
    step(); rst = 1'b0;
    step(); #1;
    check_eq("post_rst_grant", 32'(s_cyc), 32'd1);
    check_eq("post_rst_m1_stall", 32'(m1_stall), 32'd0);
    m1_cyc = 1'b0;
    step();

    // Two writes from m1, the second answered with an error
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF; m1_dat_o = 32'hDEADBEEF;
    step(); #1;
    check_eq("wr_s_we", 32'(s_we), 32'd1);
    check_eq("wr_s_sel", 32'(s_sel), 32'hF);
    check_eq("wr_s_dat", s_dat_o, 32'hDEADBEEF);
    step(); step();
    m1_stb = 1'b0; s_ack = 1'b1; #1;
    check_eq("wr0_ack", 32'(m1_ack), 32'd1);
    check_eq("wr0_err", 32'(m1_err), 32'd0);
    step(); s_ack = 1'b0; s_err = 1'b1; #1;
    check_eq("wr1_err", 32'(m1_err), 32'd1);
    check_eq("wr1_ack", 32'(m1_ack), 32'd0);
    check_eq("wr1_m0_err", 32'(m0_err), 32'd0);
    step(); s_err = 1'b0; #1;
    check_eq("wr_done_err", 32'(m1_err), 32'd0);
    check_eq("wr_done_cnt", 32'(dut.cnt), 32'd0);
    m1_cyc = 1'b0; m1_we = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-to-one pipelined Wishbone arbiter. It shares one Wishbone slave port between two master ports, for example the instruction-side and data-side core2wb converters of an Ibex core.
- Sits between the converters and the interconnect/memory.
- Grants ownership per bus cycle (cyc), not per beat.
- Tracks outstanding accesses so responses are routed to the owning master.

Parameters:
- AW, 32, address width
- DW, 32, data width; select width is DW/8
- MAX_OUT, 4, max outstanding accepted-but-unacknowledged accesses (power of 2, >=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_cyc, m0_stb, m0_we  in  1  master 0 cycle/strobe/write
- m0_adr  in  AW  master 0 address
- m0_dat_o  in  DW  master 0 write data
- m0_sel  in  DW/8  master 0 byte select
- m0_stall, m0_ack, m0_err  out  1  master 0 stall/ack/error
- m0_dat_i  out  DW  master 0 read data
- m1_*  same set as m0_*  master 1
- s_cyc, s_stb, s_we  out  1  shared port cycle/strobe/write
- s_adr  out  AW  shared address
- s_dat_o  out  DW  shared write data
- s_sel  out  DW/8  shared byte select
- s_stall, s_ack, s_err  in  1  slave stall/ack/error
- s_dat_i  in  DW  slave read data

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- FSM states: IDLE, OWN0, OWN1. Reset values:
  - state=IDLE, last=1 (so m0 wins the first tie), cnt=0.
  - All outputs inactive: s_cyc=s_stb=0; mX_stall=1, mX_ack=mX_err=0.
- IDLE:
  - Only m0_cyc -> OWN0. Only m1_cyc -> OWN1.
  - Both -> the master not equal to last.
  - Grant is registered: one-cycle arbitration latency; no shared-port activity in IDLE.
- OWNx entry: last<=x.
- OWNx behaviour:
  - s_cyc=mx_cyc.
  - s_stb=mx_stb & ~full, where full = (cnt==MAX_OUT).
  - s_adr/s_we/s_dat_o/s_sel = master x fields.
  - mx_stall = s_stall | full.
  - mx_ack=s_ack, mx_err=s_err, mx_dat_i=s_dat_i.
- Non-owner master: stall=1, ack=0, err=0, dat_i=0.
- Counter cnt (width clog2(MAX_OUT)+1):
  - +1 on s_stb & ~s_stall.
  - -1 on s_ack | s_err.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT; never goes below 0. A response with cnt==0 is ignored for counting but still forwarded.
- Release:
  - OWNx -> IDLE when mx_cyc==0 (Wishbone abort semantics). cnt is cleared to 0.
  - One dead cycle in IDLE before the next grant, giving round-robin fairness.
- Grant never changes while the owner's cyc is high, regardless of the other master.
- Reset mid-cycle: immediately IDLE, cnt=0, all outputs inactive. Outstanding slave responses are the slave's responsibility.

Optional Feature:
- Macro WB_ARB_FIXED_PRIO_EN.
- Defined: tie in IDLE always grants m0; last is unused.
- Undefined: round-robin as above.
- Single-master behaviour is identical in both builds.

Test Plan:
- Reset with both cyc=0:
  - During rst: s_cyc=0, m0_stall=m1_stall=1.
  - After release, m0_cyc=1 with stb, adr=0x100: OWN0 on the next edge. One cycle later s_stb=1, s_adr=0x100.
- m0 issues 3 back-to-back reads (0x0, 0x4, 0x8); slave acks with data 0xA, 0xB, 0xC after 2 cycles each:
  - m0_ack pulses 3 times with the data in order.
  - m1_ack stays 0; cnt returns to 0.
- MAX_OUT=4, slave never acks, m0 strobes 6 times:
  - Exactly 4 s_stb accepts.
  - m0_stall=1 from the cycle cnt hits 4 until the first ack, after which one more is accepted.
- m0_cyc and m1_cyc rise in the same cycle, repeated for 4 transactions (each cyc held for 1 access):
  - Grants alternate m0, m1, m0, m1 with one IDLE cycle between.
  - With WB_ARB_FIXED_PRIO_EN defined: all grants go to m0 while m0 keeps requesting.
- m1 owns the bus and m0_cyc asserts mid-cycle:
  - m0_stall=1 and the grant is held until m1_cyc falls.
  - m0 is granted 2 cycles after m1_cyc falls.
- Assert rst while in OWN1 with cnt=2:
  - Next cycle s_cyc=0, cnt=0.
  - After rst release, a new m1 request is granted normally.
- s_err on the second of 2 writes from m1 (sel=0xF, dat=0xDEADBEEF):
  - m1_err pulses once, m1_ack pulses once for the first write, cnt=0 afterwards.
